// File: rtl/aos_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aos_arb_pkg
// Brief    : Shared types and constants for the AOS stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package aos_arb_pkg;

  localparam int FRAME_W_BITS = 9;
  localparam int CNT_W        = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef logic owner_t;

  // A programmed width of zero still moves one beat per frame.
  function automatic logic [FRAME_W_BITS-1:0] norm_width(input logic [FRAME_W_BITS-1:0] w);
    return (w == '0) ? FRAME_W_BITS'(1) : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aos_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aos_tag_fifo
// Brief    : Owner-tag FIFO tracking frames in flight, wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
module aos_tag_fifo
  import aos_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  owner_t din_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_t head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  owner_t      r_mem [DEPTH];

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head_o  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 1'b0;
    end else begin
      if (push_i && !full_o) begin
        r_mem[r_wptr[AW-1:0]] <= din_i;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aos_strm_arb.sv
`default_nettype none
// ============================================================================
// Module   : aos_strm_arb
// Brief    : Two-requester round-robin frame arbiter into the AOS datapath,
//            with tag-routed return of results. Optional frame counters are
//            built when AOS_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module aos_strm_arb
  import aos_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FRAME_W_BITS-1:0] frame_width_i,
  input  logic [DATA_W-1:0]       s0_data_i,
  input  logic                    s0_valid_i,
  output logic                    s0_ready_o,
  input  logic [DATA_W-1:0]       s1_data_i,
  input  logic                    s1_valid_i,
  output logic                    s1_ready_o,
  output logic [DATA_W-1:0]       m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  input  logic [DATA_W-1:0]       r_data_i,
  input  logic                    r_valid_i,
  input  logic                    r_last_i,
  output logic                    r_ready_o,
  output logic [DATA_W-1:0]       d0_data_o,
  output logic                    d0_valid_o,
  output logic                    d0_last_o,
  input  logic                    d0_ready_i,
  output logic [DATA_W-1:0]       d1_data_o,
  output logic                    d1_valid_o,
  output logic                    d1_last_o,
  input  logic                    d1_ready_i,
  output logic                    busy_o,
  output logic                    owner_o,
  output logic [CNT_W-1:0]        frame_cnt0_o,
  output logic [CNT_W-1:0]        frame_cnt1_o
);

  state_t                  r_state;
  owner_t                  r_owner;
  owner_t                  r_last_owner;
  logic [FRAME_W_BITS-1:0] r_width;
  logic [FRAME_W_BITS-1:0] r_beat;

  logic   w_xfer, w_m_hs, w_push, w_pop, w_full, w_empty;
  owner_t w_grant, w_head;

  assign w_xfer     = (r_state == XFER);
  assign busy_o     = w_xfer;
  assign owner_o    = r_owner;
  assign m_data_o   = r_owner ? s1_data_i : s0_data_i;
  assign m_valid_o  = w_xfer && (r_owner ? s1_valid_i : s0_valid_i);
  assign m_last_o   = w_xfer && (r_beat == r_width - FRAME_W_BITS'(1));
  assign s0_ready_o = w_xfer && (r_owner == 1'b0) && m_ready_i;
  assign s1_ready_o = w_xfer && (r_owner == 1'b1) && m_ready_i;
  assign w_m_hs     = m_valid_o && m_ready_i;
  assign w_push     = w_m_hs && m_last_o;

  // On a tie the requester that did not own the previous frame wins.
  assign w_grant = (s0_valid_i && s1_valid_i) ? ~r_last_owner : s1_valid_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_width      <= FRAME_W_BITS'(1);
      r_beat       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((s0_valid_i || s1_valid_i) && !w_full) begin
            r_state <= XFER;
            r_owner <= w_grant;
            r_width <= norm_width(frame_width_i);
            r_beat  <= '0;
          end
        end
        XFER: begin
          if (w_m_hs) begin
            if (m_last_o) begin
              r_state      <= IDLE;
              r_last_owner <= r_owner;
            end else begin
              r_beat <= r_beat + FRAME_W_BITS'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  aos_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (r_owner),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // Results return in frame order, so the FIFO head names their destination.
  assign r_ready_o  = !w_empty && (w_head ? d1_ready_i : d0_ready_i);
  assign d0_data_o  = r_data_i;
  assign d1_data_o  = r_data_i;
  assign d0_valid_o = !w_empty && (w_head == 1'b0) && r_valid_i;
  assign d1_valid_o = !w_empty && (w_head == 1'b1) && r_valid_i;
  assign d0_last_o  = !w_empty && (w_head == 1'b0) && r_last_i;
  assign d1_last_o  = !w_empty && (w_head == 1'b1) && r_last_i;
  assign w_pop      = r_valid_i && r_ready_o && r_last_i;

`ifdef AOS_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_push) begin
      if (r_owner) r_cnt1 <= r_cnt1 + CNT_W'(1);
      else         r_cnt0 <= r_cnt0 + CNT_W'(1);
    end
  end

  assign frame_cnt0_o = r_cnt0;
  assign frame_cnt1_o = r_cnt1;
`else
  assign frame_cnt0_o = '0;
  assign frame_cnt1_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aos_strm_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_aos_strm_arb
// Brief    : Self-checking bench for aos_strm_arb against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aos_strm_arb;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef AOS_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [8:0]    fw;
  logic [DW-1:0] s0d, s1d, rd;
  logic          s0v, s1v, mr, rv, rl, d0r, d1r;
  logic          s0_ready_o, s1_ready_o, m_valid_o, m_last_o, r_ready_o;
  logic          d0_valid_o, d0_last_o, d1_valid_o, d1_last_o, busy_o, owner_o;
  logic [DW-1:0] m_data_o, d0_data_o, d1_data_o;
  logic [15:0]   frame_cnt0_o, frame_cnt1_o;

  aos_strm_arb #(.DATA_W(DW), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .frame_width_i(fw),
    .s0_data_i(s0d), .s0_valid_i(s0v), .s0_ready_o(s0_ready_o),
    .s1_data_i(s1d), .s1_valid_i(s1v), .s1_ready_o(s1_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(mr), .m_last_o(m_last_o),
    .r_data_i(rd), .r_valid_i(rv), .r_last_i(rl), .r_ready_o(r_ready_o),
    .d0_data_o(d0_data_o), .d0_valid_o(d0_valid_o), .d0_last_o(d0_last_o), .d0_ready_i(d0r),
    .d1_data_o(d1_data_o), .d1_valid_o(d1_valid_o), .d1_last_o(d1_last_o), .d1_ready_i(d1r),
    .busy_o(busy_o), .owner_o(owner_o),
    .frame_cnt0_o(frame_cnt0_o), .frame_cnt1_o(frame_cnt1_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference: who holds the grant, how far into the frame, and
  // the ordered list of frame owners whose results are still outstanding.
  bit            mb;
  bit            mo;
  bit            mlo;
  int            mw, mbeat;
  int            tq[$];
  int            cnt[2];
  logic [DW-1:0] sb[2];

  int            grants[$];
  bit            prev_busy;
  logic [DW-1:0] last_data;
  int            n_last, n_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit ne, exp_mv, exp_last, exp_rr, hs, full;
    int hd;
    s0d = sb[0];
    s1d = sb[1];
    #1;
    if (!rst) begin
      mb = 0; mo = 0; mlo = 1; mw = 1; mbeat = 0;
      tq.delete(); cnt[0] = 0; cnt[1] = 0;
    end
    ne       = (tq.size() > 0);
    hd       = ne ? tq[0] : 0;
    exp_mv   = mb && (mo ? s1v : s0v);
    exp_last = mb && (mbeat == mw - 1);
    exp_rr   = ne && (hd != 0 ? d1r : d0r);
    chk("busy", busy_o, mb);
    chk("owner", owner_o, mo);
    chk("m_valid", m_valid_o, exp_mv);
    if (exp_mv) chk("m_data", m_data_o, sb[mo]);
    chk("m_last", m_last_o, exp_last);
    chk("s0_ready", s0_ready_o, mb && !mo && mr);
    chk("s1_ready", s1_ready_o, mb && mo && mr);
    chk("r_ready", r_ready_o, exp_rr);
    chk("d0_valid", d0_valid_o, ne && hd == 0 && rv);
    chk("d1_valid", d1_valid_o, ne && hd == 1 && rv);
    if (ne && hd == 0 && rv) begin
      chk("d0_data", d0_data_o, rd);
      chk("d0_last", d0_last_o, rl);
    end
    if (ne && hd == 1 && rv) begin
      chk("d1_data", d1_data_o, rd);
      chk("d1_last", d1_last_o, rl);
    end
    chk("frame_cnt0", frame_cnt0_o, cnt[0]);
    chk("frame_cnt1", frame_cnt1_o, cnt[1]);

    if (busy_o === 1'b1 && !prev_busy) grants.push_back(int'(owner_o));
    prev_busy = (busy_o === 1'b1);
    if (m_valid_o === 1'b1 && mr) begin
      n_hs++;
      if (m_last_o === 1'b1) begin
        n_last++;
        last_data = m_data_o;
      end
    end

    if (rst) begin
      hs   = exp_mv && mr;
      full = (tq.size() >= DEPTH);
      if (rv && exp_rr && rl) void'(tq.pop_front());
      if (mb) begin
        if (hs) begin
          sb[mo] = sb[mo] + 1'b1;
          if (exp_last) begin
            tq.push_back(int'(mo));
            mb  = 0;
            mlo = mo;
            if (STATS) cnt[mo]++;
          end else begin
            mbeat++;
          end
        end
      end else if ((s0v || s1v) && !full) begin
        mb    = 1;
        mo    = (s0v && s1v) ? !mlo : s1v;
        mw    = (fw == 0) ? 1 : int'(fw);
        mbeat = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    fw = 9'd1; s0v = 0; s1v = 0; mr = 0; rv = 0; rl = 0; rd = '0; d0r = 0; d1r = 0;
    sb[0] = 8'h00; sb[1] = 8'h80; s0d = sb[0]; s1d = sb[1];
    prev_busy = 0; n_last = 0; n_hs = 0; last_data = '0;
    @(negedge clk);

    // Reset state, including with requests and results pending.
    rst = 0; run(1);
    s0v = 1; s1v = 1; rv = 1; rl = 1; d0r = 1; d1r = 1; mr = 1; run(1);
    s0v = 0; s1v = 0; rv = 0; rst = 1; run(1);

    // Both requesters always valid: alternating grants, two beats each.
    grants.delete();
    fw = 9'd2; s0v = 1; s1v = 1; mr = 1; rv = 1; rl = 1; d0r = 1; d1r = 1;
    run(12);
    s0v = 0; s1v = 0; run(3);
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

    // Single 4-beat frame from requester 0.
    rv = 0; fw = 9'd4; sb[0] = 8'h10; n_last = 0;
    s0v = 1; run(5);
    s0v = 0; run(1);
    chk("w4_last_count", n_last, 1);
    chk("w4_last_data", last_data, 8'h13);

    // One frame from requester 1, then split results with d0 back-pressure.
    fw = 9'd2; s1v = 1; run(3);
    s1v = 0;
    rv = 1; rl = 0; d0r = 0; d1r = 1; rd = 8'h5a; run(2);
    d0r = 1;
    for (int j = 0; j < 7; j++) begin
      rd = DW'($urandom);
      rl = (j == 3 || j == 6);
      run(1);
    end
    rv = 0; rl = 0; run(1);

    // Tag FIFO full holds the fifth frame until a result frame retires.
    grants.delete();
    fw = 9'd1; s0v = 1; mr = 1; run(14);
    chk("full_grants", grants.size(), 4);
    chk("full_busy", busy_o, 1'b0);
    rv = 1; rl = 1; d0r = 1; run(3);
    s0v = 0; run(1);
    chk("full_release", grants.size(), 5);
    run(6);

    // Width 0 behaves as 1; width changes mid-frame are ignored.
    n_last = 0;
    fw = 9'd0; s0v = 1; run(6);
    s0v = 0; run(1);
    chk("w0_frames", n_last, 3);
    fw = 9'd8; s1v = 1; run(1);
    fw = 9'd2; n_last = 0; n_hs = 0; run(8);
    s1v = 0; run(1);
    chk("w8_beats", n_hs, 8);
    chk("w8_last", n_last, 1);

    // Reset in the middle of a frame with two tags pending.
    rv = 0; rl = 0; fw = 9'd1; s0v = 1; run(4);
    fw = 9'd8; run(4);
    rv = 1; rl = 1; d0r = 1; d1r = 1; rst = 0; run(1);
    chk("rst_r_ready", r_ready_o, 1'b0);
    chk("rst_d0_valid", d0_valid_o, 1'b0);
    chk("rst_m_valid", m_valid_o, 1'b0);
    rst = 1; s0v = 0; rv = 0; run(1);

    // Three frames from requester 1 for the frame counters.
    fw = 9'd1; s1v = 1; run(6);
    s1v = 0; run(1);
    chk("stats_cnt1", frame_cnt1_o, STATS ? 3 : 0);
    chk("stats_cnt0", frame_cnt0_o, 0);

    // Random traffic on every input.
    for (int i = 0; i < 800; i++) begin
      s0v = ($urandom_range(0, 3) != 0);
      s1v = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 3) != 0);
      fw  = 9'($urandom_range(0, 5));
      rv  = $urandom_range(0, 1);
      rl  = ($urandom_range(0, 2) == 0);
      rd  = DW'($urandom);
      d0r = ($urandom_range(0, 3) != 0);
      d1r = ($urandom_range(0, 3) != 0);
      run(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aos_strm_arb.md
AOS_STRM_ARB -- requirements
Module: aos_strm_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stream byte width.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, max frames in flight inside the AOS datapath (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_width_i  in  9  beats per frame; 0 treated as 1.
REQ-006 SHALL have ports s0_data_i/s1_data_i  in  DATA_W  requester 0/1 input bytes.
REQ-007 SHALL have ports s0_valid_i/s1_valid_i  in  1, and s0_ready_o/s1_ready_o  out  1: requester handshakes.
REQ-008 SHALL have ports m_data_o  out  DATA_W, m_valid_o  out  1, m_ready_i  in  1, m_last_o  out  1: stream into the AOS datapath.
REQ-009 SHALL have ports r_data_i  in  DATA_W, r_valid_i  in  1, r_last_i  in  1, r_ready_o  out  1: result stream from the AOS datapath.
REQ-010 SHALL have ports d0_/d1_ data_o  out  DATA_W, valid_o  out  1, last_o  out  1, ready_i  in  1: per-requester result streams.
REQ-011 SHALL have ports busy_o  out  1 (frame granted), owner_o  out  1 (current grant), frame_cnt0_o/frame_cnt1_o  out  16.

Function
REQ-012 SHALL implement FSM IDLE, XFER; reset state IDLE.
REQ-013 IDLE -> XFER when any s*_valid_i=1 and tag FIFO not full; otherwise stay IDLE.
REQ-014 Grant SHALL be round-robin: both valid -> requester != last_owner; one valid -> that requester.
REQ-015 On grant: owner_o <= granted id; width_q <= frame_width_i (0 -> 1); beat_cnt <= 0; frame_width_i changes mid-frame SHALL be ignored.
REQ-016 In XFER: m_data_o/m_valid_o mirror the granted requester; granted s*_ready_o = m_ready_i; non-granted s*_ready_o = 0; in IDLE all s*_ready_o = 0, m_valid_o = 0.
REQ-017 beat_cnt SHALL increment on each m handshake; m_last_o = XFER && (beat_cnt == width_q-1).
REQ-018 On m handshake with m_last_o=1: push owner into tag FIFO, last_owner <= owner, -> IDLE (one-cycle bubble between frames).
REQ-019 Requester deasserting valid mid-frame SHALL stall the frame; no preemption, no timeout.
REQ-020 Return path: tag FIFO empty -> r_ready_o=0, d*_valid_o=0; else route r_* to d[head tag], r_ready_o = d[head]_ready_i, other d*_valid_o=0.
REQ-021 d*_last_o = r_last_i on routed requester; pop tag on r handshake with r_last_i=1.
REQ-022 Simultaneous push and pop SHALL both take effect; full determined before push (count unchanged).
REQ-023 busy_o = (state==XFER).

Reset
REQ-024 On rst low: state IDLE, beat_cnt 0, width_q 1, owner_o 0, last_owner 1 (requester 0 wins first tie), tag FIFO empty, counters 0; all valid/ready outputs 0.
REQ-025 Reset mid-frame SHALL discard the partial frame and all pending tags without further handshakes.

Configuration
REQ-026 Macro AOS_ARB_STATS_EN defined: frame_cnt0_o/frame_cnt1_o increment (wrap at 16 bits) on each frame-completing m handshake of that requester.
REQ-027 Macro AOS_ARB_STATS_EN undefined: counters not built, frame_cnt*_o tied to 0; ports remain.

Structure
REQ-028 Package aos_arb_pkg SHALL hold state enum (IDLE, XFER), owner_t (1 bit), FRAME_W_BITS=9, CNT_W=16.
REQ-029 Tag FIFO SHALL be sub-module aos_tag_fifo (push/pop/full/empty/head, depth TAG_DEPTH, pointers with wrap bit).

Verification
REQ-030 frame_width_i=4, s0 sends 4 bytes 0x10..0x13, m_ready_i=1 -> m_last_o on 0x13 only, busy_o falls next cycle, one tag(0) pushed.
REQ-031 s0 and s1 both valid continuously, width 2 -> grant order 0,1,0,1; each frame 2 beats; s non-granted ready always 0.
REQ-032 TAG_DEPTH=4, r_valid_i=0, 5 frames requested -> 4 granted, 5th held in IDLE until one r_last_i handshake pops a tag.
REQ-033 Tags 0,1 queued, r stream 3 bytes + last then 2 bytes + last -> first frame on d0 only, second on d1 only, d0_ready_i=0 stalls r_ready_o.
REQ-034 frame_width_i=0 -> every beat has m_last_o=1; frame_width_i changed 8->2 mid-frame -> frame still 8 beats.
REQ-035 rst low on beat 3 of 8 with 2 tags pending -> next cycle all valids 0, tag FIFO empty; with AOS_ARB_STATS_EN, 3 frames from s1 -> frame_cnt1_o=3.
